// File: rtl/siso_layer_sequencer_pkg.sv
// siso_layer_sequencer_pkg: FSM encoding and row-unit geometry defaults shared with the row unit and E memory
package siso_layer_sequencer_pkg;
  localparam int SISO_LAYERS    = 2;
  localparam int SISO_ADDRDEPTH = 20;
  localparam int SISO_ADDRWIDTH = 5;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;
endpackage

// File: rtl/siso_layer_sequencer_layer_addr_counter.sv
// layer_addr_counter: walks addresses of a layer, then layers, then a saturating iteration count
module layer_addr_counter
  import siso_layer_sequencer_pkg::*;
#(
  parameter int LAYERS    = SISO_LAYERS,
  parameter int ADDRDEPTH = SISO_ADDRDEPTH,
  parameter int ADDRWIDTH = SISO_ADDRWIDTH,
  parameter int MAX_ITER  = 10,
  parameter int ITERBITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  input  logic                 carry,
  input  logic                 step,
  output logic                 layer,
  output logic [ADDRWIDTH-1:0] addr,
  output logic [ITERBITS-1:0]  iter,
  output logic                 wrap,
  output logic                 last
);
  localparam logic                 LAST_L = 1'(LAYERS - 1);
  localparam logic [ADDRWIDTH-1:0] LAST_A = ADDRWIDTH'(ADDRDEPTH - 1);
  localparam logic [ITERBITS-1:0]  LAST_I = ITERBITS'(MAX_ITER - 1);
  logic                 layer_q, layer_d, adv;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [ITERBITS-1:0]  iter_q, iter_d;
  always_comb begin
    wrap    = addr_q == LAST_A;
    last    = layer_q == LAST_L && iter_q == LAST_I;
    adv     = step || (inc && wrap && carry);
    addr_d  = clr ? '0 : inc ? (wrap ? '0 : addr_q + ADDRWIDTH'(1)) : addr_q;
    layer_d = clr ? 1'b0 : adv ? (layer_q == LAST_L ? 1'b0 : layer_q + 1'b1) : layer_q;
    iter_d  = clr ? '0 : (adv && layer_q == LAST_L && iter_q != LAST_I) ? iter_q + ITERBITS'(1) : iter_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      layer_q <= 1'b0;
      addr_q  <= '0;
      iter_q  <= '0;
    end else begin
      layer_q <= layer_d;
      addr_q  <= addr_d;
      iter_q  <= iter_d;
    end
  end
  assign layer = layer_q;
  assign addr  = addr_q;
  assign iter  = iter_q;
endmodule

// File: rtl/siso_layer_sequencer.sv
// siso_layer_sequencer: issues layer/address reads to the SISO row unit and tracks its writebacks
module siso_layer_sequencer
  import siso_layer_sequencer_pkg::*;
#(
  parameter int LAYERS           = SISO_LAYERS,
  parameter int ADDRWIDTH        = SISO_ADDRWIDTH,
  parameter int ADDRDEPTH        = SISO_ADDRDEPTH,
  parameter int MAX_ITER         = 10,
  parameter int ITERBITS         = 4,
  parameter int OSWIDTH          = 6,
  parameter bit DRAIN_EACH_LAYER = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hold,
  input  logic                 wren_in,
  input  logic                 wrlayer_in,
  input  logic [ADDRWIDTH-1:0] wraddress_in,
  output logic                 rdlayer,
  output logic [ADDRWIDTH-1:0] rdaddress,
  output logic                 rden_LLR,
  output logic                 rden_E,
  output logic                 busy,
  output logic                 done,
  output logic [ITERBITS-1:0]  iter_count,
  output logic                 wb_err
);
  state_e               state_q, state_d;
  logic [OSWIDTH-1:0]   os_q, os_d;
  logic [ADDRWIDTH-1:0] rdaddress_q, rdaddress_d, is_addr, ex_addr;
  logic [ITERBITS-1:0]  ex_iter;
  logic rden_llr_q, rden_llr_d, rden_e_q, rden_e_d, rdlayer_q, rdlayer_d;
  logic busy_q, busy_d, done_q, done_d, wb_err_q, wb_err_d, ign_q;
  logic accept, issue, drained, wb, dec, mismatch;
  logic is_layer, is_wrap, is_last, ex_layer, ex_wrap, ex_last, ex_unused;
  layer_addr_counter #(
    .LAYERS(LAYERS), .ADDRDEPTH(ADDRDEPTH), .ADDRWIDTH(ADDRWIDTH), .MAX_ITER(MAX_ITER), .ITERBITS(ITERBITS)
  ) u_issue (
    .clk(clk), .rst(rst), .clr(state_q == DONE), .inc(issue),
    .carry(!DRAIN_EACH_LAYER && !is_last), .step(drained && !is_last),
    .layer(is_layer), .addr(is_addr), .iter(iter_count), .wrap(is_wrap), .last(is_last)
  );
  layer_addr_counter #(
    .LAYERS(LAYERS), .ADDRDEPTH(ADDRDEPTH), .ADDRWIDTH(ADDRWIDTH), .MAX_ITER(MAX_ITER), .ITERBITS(ITERBITS)
  ) u_expect (
    .clk(clk), .rst(rst), .clr(state_q == DONE || accept), .inc(wb),
    .carry(!ex_last), .step(1'b0),
    .layer(ex_layer), .addr(ex_addr), .iter(ex_iter), .wrap(ex_wrap), .last(ex_last)
  );
  assign ex_unused = ^{ex_iter, ex_wrap};
  always_comb begin
    accept      = state_q == IDLE && start;
    issue       = accept || (state_q == ISSUE && !hold);
    drained     = state_q == DRAIN && os_q == '0 && !rden_llr_q;
    wb          = wren_in && !ign_q;
    dec         = wb && os_q != '0;
    mismatch    = {wrlayer_in, wraddress_in} != {ex_layer, ex_addr};
    state_d     = (issue && is_wrap && (DRAIN_EACH_LAYER || is_last)) ? DRAIN :
                  accept ? ISSUE :
                  drained ? (is_last ? DONE : ISSUE) :
                  state_q == DONE ? IDLE : state_q;
    os_d        = (rden_llr_q && !dec) ? os_q + OSWIDTH'(1) : (!rden_llr_q && dec) ? os_q - OSWIDTH'(1) : os_q;
    wb_err_d    = !accept && (wb_err_q || (wb && (os_q == '0 || mismatch)));
    rden_llr_d  = issue;
    rden_e_d    = issue && iter_count != '0;
    rdlayer_d   = issue ? is_layer : rdlayer_q;
    rdaddress_d = issue ? is_addr : rdaddress_q;
    busy_d      = state_d == ISSUE || state_d == DRAIN;
    done_d      = state_d == DONE;
  end
  // ign_q masks stale writebacks from a row unit still flushing in the cycle after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      os_q        <= '0;
      rden_llr_q  <= 1'b0;
      rden_e_q    <= 1'b0;
      rdlayer_q   <= 1'b0;
      rdaddress_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wb_err_q    <= 1'b0;
      ign_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      os_q        <= os_d;
      rden_llr_q  <= rden_llr_d;
      rden_e_q    <= rden_e_d;
      rdlayer_q   <= rdlayer_d;
      rdaddress_q <= rdaddress_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wb_err_q    <= wb_err_d;
      ign_q       <= 1'b0;
    end
  end
  assign rdlayer   = rdlayer_q;
  assign rdaddress = rdaddress_q;
  assign rden_LLR  = rden_llr_q;
  assign rden_E    = rden_e_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wb_err    = wb_err_q;
endmodule

// File: tb/tb_siso_layer_sequencer.sv
// tb_siso_layer_sequencer: directed runs against a 12-cycle echo row-unit stub with a reference walk model
module tb_siso_layer_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, hold = 1'b0, inj = 1'b0, swap = 1'b0;
  logic wren_in, wrlayer_in, rdlayer, rden_LLR, rden_E, busy, done, wb_err;
  logic [4:0] wraddress_in, rdaddress;
  logic [3:0] iter_count;
  logic [6:0] pipe [12];
  int checks = 0, errors = 0;
  int cyc = 0, wb_cnt, rows, erows, done_cnt, seq_err, drain_err, min_gap, gap7, last_iss, sw_cyc, err_cyc;
  bit sw_seen, err_seen;
  logic ml;
  logic [4:0] ma;
  logic [3:0] mi;
  typedef struct {bit swap; int hold_len; int rows; int erows; int dones; bit err; int gap7;} vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  siso_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .wren_in(wren_in), .wrlayer_in(wrlayer_in), .wraddress_in(wraddress_in),
    .rdlayer(rdlayer), .rdaddress(rdaddress), .rden_LLR(rden_LLR), .rden_E(rden_E),
    .busy(busy), .done(done), .iter_count(iter_count), .wb_err(wb_err)
  );

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 12; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {rden_LLR, rdlayer, rdaddress};
      for (int i = 1; i < 12; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    wren_in      = pipe[11][6] || inj;
    wrlayer_in   = pipe[11][5];
    wraddress_in = pipe[11][4:0];
    if (swap && pipe[11][4:0] == 5'd3) wraddress_in = 5'd4;
    else if (swap && pipe[11][4:0] == 5'd4) wraddress_in = 5'd3;
  end

  always @(negedge clk) begin
    int gap;
    cyc++;
    if (wren_in) wb_cnt++;
    if (wren_in && swap && wraddress_in == 5'd4 && !sw_seen) begin sw_seen = 1; sw_cyc = cyc; end
    if (wb_err && busy && !err_seen) begin err_seen = 1; err_cyc = cyc; end
    if (done) begin done_cnt++; if (busy) seq_err++; end
    if (rden_LLR) begin
      if ({rdlayer, rdaddress} != {ml, ma} || iter_count != mi || rden_E != (mi != 4'd0)) seq_err++;
      if (ma == 5'd0 && rows > 0) begin
        gap = cyc - last_iss;
        if (gap < min_gap) min_gap = gap;
        if (wb_cnt != rows) drain_err++;
      end
      if (ma == 5'd7 && !ml && mi == 4'd0) gap7 = cyc - last_iss;
      rows++;
      if (rden_E) erows++;
      last_iss = cyc;
      if (ma == 5'd19) begin
        ma = 5'd0;
        if (ml) begin ml = 1'b0; if (mi != 4'd9) mi = mi + 4'd1; end
        else ml = 1'b1;
      end else ma = ma + 5'd1;
    end else if (rden_E) seq_err++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    @(negedge clk);
    swap = v.swap;
    wb_cnt = 0; rows = 0; erows = 0; done_cnt = 0; seq_err = 0; drain_err = 0;
    min_gap = 1000; gap7 = 0; last_iss = 0; sw_seen = 0; err_seen = 0; sw_cyc = 0; err_cyc = 0;
    ml = 1'b0; ma = 5'd0; mi = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_first_issue"}, rden_LLR, 1);
    chk({tag, "_err_cleared"}, wb_err, 0);
    if (v.hold_len > 0) begin
      for (int i = 0; i < 50 && !(rden_LLR && rdaddress == 5'd6); i++) @(negedge clk);
      hold = 1'b1;
      repeat (v.hold_len) @(negedge clk);
      hold = 1'b0;
    end
    for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
    chk({tag, "_done_reached"}, done, 1);
    repeat (15) @(negedge clk);
    chk({tag, "_rows"}, rows, v.rows);
    chk({tag, "_erows"}, erows, v.erows);
    chk({tag, "_done_pulses"}, done_cnt, v.dones);
    chk({tag, "_sequence"}, seq_err, 0);
    chk({tag, "_drain_before_layer"}, drain_err, 0);
    chk({tag, "_layer_gap_ge12"}, min_gap >= 12, 1);
    chk({tag, "_gap_at_addr7"}, gap7, v.gap7);
    chk({tag, "_err_seen"}, err_seen, v.err);
    chk({tag, "_err_sticky"}, wb_err, v.err);
    chk({tag, "_idle_busy"}, busy, 0);
    if (v.swap) chk({tag, "_err_latency"}, err_cyc - sw_cyc, 1);
    swap = 1'b0;
  endtask

  initial begin
    vecs[0] = '{swap: 1'b0, hold_len: 0, rows: 400, erows: 360, dones: 1, err: 1'b0, gap7: 1};
    vecs[1] = '{swap: 1'b0, hold_len: 5, rows: 400, erows: 360, dones: 1, err: 1'b0, gap7: 6};
    vecs[2] = '{swap: 1'b1, hold_len: 0, rows: 400, erows: 360, dones: 1, err: 1'b1, gap7: 1};
    vecs[3] = '{swap: 1'b0, hold_len: 0, rows: 400, erows: 360, dones: 1, err: 1'b0, gap7: 1};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rdlayer, rdaddress, rden_LLR, rden_E, busy, done, iter_count, wb_err}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_issue", {rden_LLR, busy}, 0);
    for (int k = 0; k < 4; k++) run(vecs[k], $sformatf("vec%0d", k));
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    chk("extra_wb_err", wb_err, 1);
    chk("extra_wb_no_underflow", int'(dut.os_q), 0);
    @(negedge clk);
    chk("extra_wb_err_sticky", wb_err, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_clears_err", wb_err, 0);
    for (int i = 0; i < 3000 && !(rden_LLR && iter_count == 4'd2 && rdaddress == 5'd11); i++) @(negedge clk);
    chk("reach_iter2_addr11", rden_LLR && iter_count == 4'd2 && rdaddress == 5'd11, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rden", {rden_LLR, rden_E}, 0);
    chk("midrst_addr", {rdlayer, rdaddress}, 0);
    chk("midrst_status", {busy, done, wb_err}, 0);
    chk("midrst_iter", iter_count, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_quiet", {rden_LLR, busy, wb_err}, 0);
    run(vecs[0], "post_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
